// File: rtl/program_counter.sv
// program_counter: sequencer for a small instruction fetch path.
//
// Three states: IDLE, RUN and HALT. start (from IDLE or HALT) enters RUN at address 0.
// In RUN, with stall low, exactly one action is applied per cycle. Priority is
// halt_req > call > ret > abs_jump > rel_branch > increment.
// Reset is synchronous and active-high. All outputs come straight from registers.
//
// Optional feature (macro PC_RET_STACK_EN): a 4-entry LIFO of D-bit return addresses.
//   - call pushes prog_ctr+1, then jumps to target.
//   - ret pops the top entry into prog_ctr.
//   - Overflow or underflow sets the sticky stack_err flag.
// Without the macro:
//   - call behaves as abs_jump.
//   - ret behaves as increment.
//   - stack_err is tied low.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset
//   start      - begin execution at address 0 (ignored in RUN)
//   stall      - hold all state this cycle (RUN only)
//   halt_req   - end program, prog_ctr holds
//   abs_jump   - prog_ctr <= target
//   rel_branch - prog_ctr <= prog_ctr + target (two's complement, wraps)
//   call       - push return address, jump to target
//   ret        - pop return address into prog_ctr
//   target     - D-bit branch target
//   prog_ctr   - current instruction address
//   running    - high in RUN
//   done       - high in HALT
//   stack_err  - sticky return-stack overflow/underflow flag
module program_counter #(
  parameter int unsigned D = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         halt_req,
  input  logic         abs_jump,
  input  logic         rel_branch,
  input  logic         call,
  input  logic         ret,
  input  logic [D-1:0] target,
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         done,
  output logic         stack_err
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [D-1:0]   pc_inc;

  assign pc_inc = pc_q + D'(1);

`ifdef PC_RET_STACK_EN
  logic [D-1:0] stack_q [4];
  logic [2:0]   sp_q, sp_d;
  logic [1:0]   top_idx;
  logic         push;
  logic         err_q, err_d;

  assign top_idx = sp_q[1:0] - 2'd1;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_RET_STACK_EN
    sp_d    = sp_q;
    push    = 1'b0;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d = StRun;
          pc_d    = '0;
        end
      end
      StRun: begin
        if (!stall) begin
          if (halt_req) begin
            state_d = StHalt;
          end else if (call) begin
`ifdef PC_RET_STACK_EN
            if (sp_q == 3'd4) begin
              // Full: keep the stack intact but still take the jump.
              err_d = 1'b1;
            end else begin
              push = 1'b1;
              sp_d = sp_q + 3'd1;
            end
`endif
            pc_d = target;
          end else if (ret) begin
`ifdef PC_RET_STACK_EN
            if (sp_q == 3'd0) begin
              err_d = 1'b1;
              pc_d  = pc_inc;
            end else begin
              sp_d = sp_q - 3'd1;
              pc_d = stack_q[top_idx];
            end
`else
            pc_d = pc_inc;
`endif
          end else if (abs_jump) begin
            pc_d = target;
          end else if (rel_branch) begin
            pc_d = pc_q + target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_RET_STACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= 3'd0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Entries need no reset: the pointer alone defines what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      stack_q[sp_q[1:0]] <= pc_inc;
    end
  end

  assign stack_err = err_q;
`else
  assign stack_err = 1'b0;
`endif

  assign prog_ctr = pc_q;
  assign running  = (state_q == StRun);
  assign done     = (state_q == StHalt);

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL have parameter D, default 10: program-counter and jump-target width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: begin execution at address 0.
REQ-005 SHALL have port stall, input, 1 bit: hold all state this cycle.
REQ-006 SHALL have port halt_req, input, 1 bit: end program.
REQ-007 SHALL have port abs_jump, input, 1 bit: load target into the PC.
REQ-008 SHALL have port rel_branch, input, 1 bit: add target, two's complement, to the PC.
REQ-009 SHALL have port call, input, 1 bit: push the return address and jump to target.
REQ-010 SHALL have port ret, input, 1 bit: pop the return address into the PC.
REQ-011 SHALL have port target, input, D bits: address from the branch-target lookup table.
REQ-012 SHALL have port prog_ctr, output, D bits: current instruction address.
REQ-013 SHALL have port running, output, 1 bit: high while in RUN.
REQ-014 SHALL have port done, output, 1 bit: high while in HALT.
REQ-015 SHALL have port stack_err, output, 1 bit: sticky return-stack overflow or underflow flag.

Function
REQ-016 SHALL implement states IDLE, RUN and HALT.
REQ-017 SHALL treat IDLE and HALT identically on start: start moves to RUN, sets prog_ctr=0 and clears done; otherwise state and prog_ctr hold.
REQ-018 SHALL ignore start while in RUN.
REQ-019 SHALL hold prog_ctr, state and the stack in RUN when stall=1, regardless of all other controls.
REQ-020 SHALL, in RUN with stall=0, apply exactly one action per cycle in priority order: halt_req > call > ret > abs_jump > rel_branch > increment.
REQ-021 SHALL, on halt_req, enter HALT with prog_ctr holding its current value.
REQ-022 SHALL, on abs_jump, set prog_ctr=target.
REQ-023 SHALL, on rel_branch, set prog_ctr=(prog_ctr+target) mod 2^D.
REQ-024 SHALL, on increment, set prog_ctr=(prog_ctr+1) mod 2^D, so 2^D-1 wraps to 0.
REQ-025 SHALL have one-cycle latency: the value follows the control values sampled at the same edge, with no combinational path from inputs to prog_ctr.
REQ-026 SHALL drive running and done from registered state only.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, override all inputs and set state=IDLE, prog_ctr=0, running=0, done=0 and stack_err=0, and empty the return stack.
REQ-028 SHALL, on reset in RUN or HALT mid-program, discard all state, with no partial completion of the in-flight action.

Configuration
REQ-029 SHALL, with macro PC_RET_STACK_EN defined, include a 4-entry LIFO return stack of D-bit entries.
REQ-030 SHALL, with PC_RET_STACK_EN defined, on call when not full, push (prog_ctr+1) mod 2^D and set prog_ctr=target.
REQ-031 SHALL, with PC_RET_STACK_EN defined, on call when full, leave the stack unchanged, set stack_err and still jump to target.
REQ-032 SHALL, with PC_RET_STACK_EN defined, on ret when not empty, set prog_ctr to the popped entry.
REQ-033 SHALL, with PC_RET_STACK_EN defined, on ret when empty, set stack_err and increment prog_ctr.
REQ-034 SHALL keep stack_err at 1 until reset.
REQ-035 SHALL, without PC_RET_STACK_EN, build no stack storage, treat call as abs_jump, treat ret as increment and tie stack_err to 0.

Verification
REQ-036 SHALL cover: reset, then start, then 5 idle cycles -> prog_ctr sequence 0,1,2,3,4,5 with running=1.
REQ-037 SHALL cover: D=10, prog_ctr=4 with rel_branch and target=10'h3FF -> prog_ctr=3; prog_ctr=1023 with increment -> prog_ctr=0.
REQ-038 SHALL cover: abs_jump, target=80, asserted together with stall=1 for 2 cycles, then stall=0 -> prog_ctr holds 2 cycles, then becomes 80.
REQ-039 SHALL cover: halt_req and abs_jump asserted in the same cycle at prog_ctr=116 -> done=1, running=0, prog_ctr=116; then start -> prog_ctr=0, done=0.
REQ-040 SHALL cover, with PC_RET_STACK_EN: call target=53 at prog_ctr=20, then ret -> prog_ctr=53, then 21; 5 nested calls -> stack_err=1 after the fifth; ret on empty -> stack_err=1.
REQ-041 SHALL cover: reset asserted mid-RUN at prog_ctr=59 with 2 stack entries -> next cycle IDLE, prog_ctr=0, stack empty, stack_err=0.
